// File: rtl/commit_trace_buf.sv
// commit_trace_buf: capture of committed regfile/SPR writes into a circular
// trace buffer. Each entry is tagged with a timestamp, thread id and channel.
// Entries are drained in order over a valid/ready stream.
module commit_trace_buf #(
  parameter int NCH   = 2,
  parameter int DEPTH = 64,
  parameter int AW    = 9,
  parameter int DW    = 32,
  parameter int TIDW  = 6,
  parameter int TSW   = 16,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int EW   = TSW + TIDW + CHW + AW + DW,
  localparam int IW   = $clog2(DEPTH),
  localparam int PW   = IW + 1
) (
  input  logic              gclk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              cfg_wrap,
  input  logic              cfg_trig,
  input  logic [TIDW-1:0]   cfg_ttid,
  input  logic [TIDW-1:0]   cm_tid,
  input  logic [NCH-1:0]    cm_valid,
  input  logic [NCH*AW-1:0] cm_addr,
  input  logic [NCH*DW-1:0] cm_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EW-1:0]     out_entry,
  output logic [PW-1:0]     count,
  output logic [1:0]        state_o,
  output logic              ovf,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_FROZEN  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [EW-1:0]  mem_q [DEPTH];
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic [TSW-1:0] ts_q, ts_d;
  logic           out_valid_q, out_valid_d;
  logic [EW-1:0]  out_entry_q, out_entry_d;
  logic           ovf_q, ovf_d;
  logic [15:0]    drop_q, drop_d;

  logic           pop_s, trig_hit_s, cap_s, discard_s, leave_idle_s;
  logic [PW-1:0]  n_s, left_s, free_s, over_s, wr_n_s, lost_s;
  logic [NCH-1:0] wr_en_s;
  logic [IW-1:0]  wr_slot_s [NCH];
  logic [EW-1:0]  wr_ent_s [NCH];
  logic [IW-1:0]  rd_idx_s;
  logic [16:0]    drop_sum_s;

  // Build per-channel entries and pack valid channels into consecutive slots.
  always_comb begin
    n_s = '0;
    for (int c = 0; c < NCH; c++) begin
      wr_ent_s[c]  = {ts_q, cm_tid, CHW'(c), cm_addr[c*AW +: AW], cm_data[c*DW +: DW]};
      // slot is offset by the number of valid channels below c
      wr_slot_s[c] = wptr_q[IW-1:0] + n_s[IW-1:0];
      if (cm_valid[c]) begin
        n_s = n_s + PW'(1);
      end else begin
        n_s = n_s;
      end
    end
  end

  // Capture decision, full handling, pointer/count update and FSM next state.
  always_comb begin
    pop_s      = out_valid_q & out_ready;
    trig_hit_s = (|cm_valid) && (cm_tid == cfg_ttid);
    cap_s      = cfg_en && ((state_q == S_CAPTURE) || ((state_q == S_ARMED) && trig_hit_s));
    // free space counts this cycle's pop so a pop and push can share a slot
    left_s     = count_q - PW'(pop_s);
    free_s     = PW'(DEPTH) - left_s;
    over_s     = '0;
    wr_n_s     = '0;
    lost_s     = '0;
    discard_s  = 1'b0;
    if (cap_s && (n_s > free_s)) begin
      if (cfg_wrap) begin
        wr_n_s = n_s;
        over_s = n_s - free_s;
        lost_s = n_s - free_s;
      end else begin
        discard_s = 1'b1;
        lost_s    = n_s;
      end
    end else if (cap_s) begin
      wr_n_s = n_s;
    end else begin
      wr_n_s = '0;
    end
    wr_en_s = (cap_s && !discard_s) ? cm_valid : '0;
    wptr_d  = wptr_q + wr_n_s;
    rptr_d  = rptr_q + PW'(pop_s) + over_s;
    count_d = left_s + wr_n_s - over_s;

    state_d = state_q;
    if (!cfg_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    state_d = cfg_trig ? S_ARMED : S_CAPTURE;
        S_ARMED:   state_d = trig_hit_s ? (discard_s ? S_FROZEN : S_CAPTURE) : S_ARMED;
        S_CAPTURE: state_d = discard_s ? S_FROZEN : S_CAPTURE;
        S_FROZEN:  state_d = S_FROZEN;
        default:   state_d = S_IDLE;
      endcase
    end

    leave_idle_s = (state_q == S_IDLE) && (state_d != S_IDLE);
    ts_d = ((state_q == S_IDLE) || (state_d == S_IDLE)) ? '0 : ts_q + TSW'(1);

    drop_sum_s = {1'b0, drop_q} + 17'(lost_s);
    if (leave_idle_s) begin
      ovf_d  = 1'b0;
      drop_d = 16'h0000;
    end else if (lost_s != '0) begin
      ovf_d  = 1'b1;
      drop_d = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end else begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
    end
  end

  // Next presented entry: head of the buffer after this cycle, bypassing same-cycle writes.
  always_comb begin
    rd_idx_s    = rptr_d[IW-1:0];
    out_entry_d = mem_q[rd_idx_s];
    for (int c = 0; c < NCH; c++) begin
      if (wr_en_s[c] && (wr_slot_s[c] == rd_idx_s)) begin
        out_entry_d = wr_ent_s[c];
      end else begin
        out_entry_d = out_entry_d;
      end
    end
    out_valid_d = (count_d != '0);
    if (!out_valid_d) begin
      out_entry_d = '0;
    end else begin
      out_entry_d = out_entry_d;
    end
  end

  // Buffer storage; contents need no reset since only counted slots are read.
  always_ff @(posedge gclk) begin
    for (int c = 0; c < NCH; c++) begin
      if (wr_en_s[c]) begin
        mem_q[wr_slot_s[c]] <= wr_ent_s[c];
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ts_q        <= '0;
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ts_q        <= ts_d;
      out_valid_q <= out_valid_d;
      out_entry_q <= out_entry_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_entry = out_entry_q;
  assign count     = count_q;
  assign state_o   = state_q;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Bench for commit_trace_buf (NCH=2, DEPTH=4): table vectors, directed
// corner-case sequences, and random traffic against a queue-based model.
module tb_commit_trace_buf;

  localparam int NCH = 2, DEPTH = 4, AW = 9, DW = 32, TIDW = 6, TSW = 16;
  localparam int EW = 64;

  logic              gclk = 1'b0;
  logic              rst;
  logic              cfg_en, cfg_wrap, cfg_trig;
  logic [TIDW-1:0]   cfg_ttid, cm_tid;
  logic [NCH-1:0]    cm_valid;
  logic [NCH*AW-1:0] cm_addr;
  logic [NCH*DW-1:0] cm_data;
  logic              out_valid, out_ready;
  logic [EW-1:0]     out_entry;
  logic [2:0]        count;
  logic [1:0]        state_o;
  logic              ovf;
  logic [15:0]       drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: queue of entries in {ts, tid, ch, addr, data} format
  logic [EW-1:0] mq[$];
  int m_state, m_ts, m_ovf, m_drop;

  commit_trace_buf #(.NCH(NCH), .DEPTH(DEPTH), .AW(AW), .DW(DW), .TIDW(TIDW), .TSW(TSW)) dut (
    .gclk(gclk), .rst(rst), .cfg_en(cfg_en), .cfg_wrap(cfg_wrap), .cfg_trig(cfg_trig),
    .cfg_ttid(cfg_ttid), .cm_tid(cm_tid), .cm_valid(cm_valid), .cm_addr(cm_addr),
    .cm_data(cm_data), .out_valid(out_valid), .out_ready(out_ready), .out_entry(out_entry),
    .count(count), .state_o(state_o), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  always #5 gclk = ~gclk;

  typedef struct {
    logic       en;
    logic [1:0] valid;
    logic       ready;
    int         exp_count;
    int         exp_state;
    logic       exp_valid;
    int         exp_ch;
    int         exp_ts;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = 0;
    m_ts    = 0;
    m_ovf   = 0;
    m_drop  = 0;
  endtask

  // one clock of the specification's rules, applied to the current inputs
  task automatic model_step();
    logic [EW-1:0] beat[$];
    int  nxt, lose;
    bit  cap, hit;
    logic cb;
    lose = 0;
    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
    hit = (cm_valid != 2'b00) && (cm_tid == cfg_ttid);
    cap = cfg_en && (m_state == 2 || (m_state == 1 && hit));
    nxt = m_state;
    if (!cfg_en) nxt = 0;
    else if (m_state == 0) nxt = cfg_trig ? 1 : 2;
    else if (m_state == 1 && hit) nxt = 2;
    if (cap) begin
      for (int c = 0; c < NCH; c++) begin
        cb = c[0];
        if (cm_valid[c]) beat.push_back({m_ts[15:0], cm_tid, cb, cm_addr[c*AW +: AW], cm_data[c*DW +: DW]});
      end
      if (mq.size() + beat.size() <= DEPTH) begin
        foreach (beat[i]) mq.push_back(beat[i]);
      end else if (cfg_wrap) begin
        foreach (beat[i]) mq.push_back(beat[i]);
        while (mq.size() > DEPTH) begin
          void'(mq.pop_front());
          lose++;
        end
      end else begin
        lose = beat.size();
        nxt  = 3;
      end
    end
    if (m_state == 0 && nxt != 0) begin
      m_ovf  = 0;
      m_drop = 0;
    end else if (lose > 0) begin
      m_ovf  = 1;
      m_drop = (m_drop + lose > 65535) ? 65535 : m_drop + lose;
    end
    m_ts    = (m_state == 0 || nxt == 0) ? 0 : (m_ts + 1) % 65536;
    m_state = nxt;
  endtask

  task automatic check_model(input string tag);
    logic [EW-1:0] e;
    e = (mq.size() != 0) ? mq[0] : '0;
    chk({tag, ".count"}, 64'(count), 64'(mq.size()));
    chk({tag, ".valid"}, 64'(out_valid), 64'(mq.size() != 0));
    chk({tag, ".state"}, 64'(state_o), 64'(m_state));
    chk({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
    chk({tag, ".drop"}, 64'(drop_cnt), 64'(m_drop));
    chk({tag, ".entry"}, out_entry, e);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge gclk);
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    cfg_en = 1'b0; cfg_wrap = 1'b0; cfg_trig = 1'b0; cfg_ttid = 6'd0;
    cm_tid = 6'd0; cm_valid = 2'b00; cm_addr = '0; cm_data = '0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge gclk);
    #1;
    rst = 1'b0;
    model_reset();
    check_model("reset");
  endtask

  task automatic beat1(input logic [1:0] v, input logic [31:0] d, input string tag);
    cm_valid = v;
    cm_data  = {32'd0, d};
    cm_addr  = {9'd0, 9'(d)};
    cycle(tag);
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'b00, 1'b0, 0, 2, 1'b0, 0, 0};
    tbl[1] = '{1'b1, 2'b11, 1'b0, 2, 2, 1'b1, 0, 0};
    tbl[2] = '{1'b1, 2'b00, 1'b1, 1, 2, 1'b1, 1, 0};
    tbl[3] = '{1'b1, 2'b00, 1'b1, 0, 2, 1'b0, 0, 0};
    tbl[4] = '{1'b1, 2'b10, 1'b0, 1, 2, 1'b1, 1, 3};
    tbl[5] = '{1'b1, 2'b00, 1'b1, 0, 2, 1'b0, 0, 0};

    rst = 1'b1;
    idle_inputs();
    #1;
    do_reset();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_entry", out_entry, 64'd0);

    // dual channel packing from the table
    for (int i = 0; i < 6; i++) begin
      cfg_en    = tbl[i].en;
      cm_valid  = tbl[i].valid;
      out_ready = tbl[i].ready;
      cm_tid    = 6'(i);
      cm_addr   = 18'($urandom);
      cm_data   = {$urandom, $urandom};
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.count", i), 64'(count), 64'(tbl[i].exp_count));
      chk($sformatf("vec%0d.state", i), 64'(state_o), 64'(tbl[i].exp_state));
      chk($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("vec%0d.ch", i), 64'(out_entry[41]), 64'(tbl[i].exp_ch));
        chk($sformatf("vec%0d.ts", i), 64'(out_entry[63:48]), 64'(tbl[i].exp_ts));
      end
    end

    // trigger: only thread 3 starts the capture
    do_reset();
    cfg_en = 1'b1; cfg_trig = 1'b1; cfg_ttid = 6'd3;
    cycle("trg_arm");
    chk("trg_armed", 64'(state_o), 64'd1);
    cm_tid = 6'd1; beat1(2'b01, 32'd1, "trg_t1");
    cm_tid = 6'd2; beat1(2'b11, 32'd2, "trg_t2");
    chk("trg_ignored", 64'(count), 64'd0);
    cm_tid = 6'd3; beat1(2'b01, 32'd3, "trg_t3");
    chk("trg_hit_count", 64'(count), 64'd1);
    chk("trg_hit_state", 64'(state_o), 64'd2);
    cm_tid = 6'd1; beat1(2'b01, 32'd4, "trg_after");
    chk("trg_after_count", 64'(count), 64'd2);

    // freeze: a beat that does not fit is discarded whole
    do_reset();
    cfg_en = 1'b1;
    cycle("frz_start");
    beat1(2'b11, 32'd1, "frz_b1");
    beat1(2'b01, 32'd2, "frz_b2");
    beat1(2'b11, 32'd3, "frz_b3");
    chk("frz_count", 64'(count), 64'd3);
    chk("frz_ovf", 64'(ovf), 64'd1);
    chk("frz_drop", 64'(drop_cnt), 64'd2);
    chk("frz_state", 64'(state_o), 64'd3);
    out_ready = 1'b1;
    beat1(2'b01, 32'd4, "frz_drain");
    chk("frz_drain_count", 64'(count), 64'd2);
    // asynchronous reset while draining
    rst = 1'b1;
    #1;
    chk("rst_async_count", 64'(count), 64'd0);
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_state", 64'(state_o), 64'd0);
    chk("rst_async_ovf", 64'(ovf), 64'd0);
    do_reset();

    // wrap: oldest entries are overwritten
    cfg_en = 1'b1; cfg_wrap = 1'b1;
    cycle("wrp_start");
    for (int i = 1; i <= 6; i++) beat1(2'b01, 32'(i), $sformatf("wrp_b%0d", i));
    chk("wrp_count", 64'(count), 64'd4);
    chk("wrp_drop", 64'(drop_cnt), 64'd2);
    out_ready = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      chk($sformatf("wrp_drain%0d", i), 64'(out_entry[31:0]), 64'(i));
      beat1(2'b00, 32'd0, $sformatf("wrp_pop%0d", i));
    end
    chk("wrp_empty", 64'(count), 64'd0);

    // concurrency: a pop frees the slot for a full-buffer push
    out_ready = 1'b0;
    for (int i = 10; i <= 13; i++) beat1(2'b01, 32'(i), "cnc_fill");
    out_ready = 1'b1;
    beat1(2'b01, 32'd14, "cnc_push_pop");
    chk("cnc_count", 64'(count), 64'd4);
    chk("cnc_drop", 64'(drop_cnt), 64'd2);
    chk("cnc_head", 64'(out_entry[31:0]), 64'd11);
    for (int i = 0; i < 4; i++) beat1(2'b00, 32'd0, "cnc_drain");
    cfg_en = 1'b0;
    cycle("cnc_off");
    chk("off_state", 64'(state_o), 64'd0);
    chk("off_ovf_kept", 64'(ovf), 64'd1);
    cfg_en = 1'b1;
    cycle("cnc_on");
    chk("on_ovf_clear", 64'(ovf), 64'd0);
    chk("on_drop_clear", 64'(drop_cnt), 64'd0);
    out_ready = 1'b0;
    beat1(2'b01, 32'd77, "cnc_ts");
    chk("on_ts_zero", 64'(out_entry[63:48]), 64'd0);

    // random traffic against the model
    do_reset();
    cfg_en = 1'b1; cfg_ttid = 6'd2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) cfg_en = ~cfg_en;
      if ($urandom_range(0, 99) == 0) cfg_wrap = ~cfg_wrap;
      cfg_trig  = 1'($urandom);
      cm_tid    = 6'($urandom_range(0, 3));
      cm_valid  = 2'($urandom);
      cm_addr   = 18'($urandom);
      cm_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 6);
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
